store_unit: RTL and testbench

//   Memory-write side of the RV32 datapath; the counterpart of the writeback path that returns load data.

---
 rtl/store_unit.sv | 169 ++++++++++++++++
 tb/tb_store_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// store_unit: memory-write side of the RV32 datapath.
// Takes one SB/SH/SW from the core and checks its alignment.
// Drives a word-aligned address, lane-replicated write data and byte strobes.
// Runs a req/ack handshake with a bounded wait, and reports done or error as one-cycle pulses.
module store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Last counter value before the request is abandoned.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic                   st_ready_q, st_ready_d;
    logic                   mem_req_q, mem_req_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic [3:0]             mem_wstrb_q, mem_wstrb_d;
    logic                   st_done_q, st_done_d;
    logic                   st_err_q, st_err_d;

    // A store is legal when funct3 names SB/SH/SW and the address is naturally aligned.
    function automatic logic store_legal(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (a[0] == 1'b0);
            3'b010:  ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replicate the low bytes of rs2 across all lanes so that any strobe lane sees the correct byte.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            3'b000:  w = {4{d[7:0]}};
            3'b001:  w = {2{d[15:0]}};
            3'b010:  w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Byte enables selected by access size and the low address bits.
    function automatic logic [3:0] lane_wstrb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3)
            3'b000:  s = 4'b0001 << a;
            3'b001:  s = a[1] ? 4'b1100 : 4'b0011;
            3'b010:  s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Next-state logic and next values for every registered output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        st_ready_d  = 1'b0;
        mem_req_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = 4'b0000;
        st_done_d   = 1'b0;
        st_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_valid) begin
                    if (store_legal(st_funct3, st_addr[1:0])) begin
                        state_d     = REQ;
                        cnt_d       = {TIMEOUT_W{1'b0}};
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {st_addr[31:2], 2'b00};
                        mem_wdata_d = lane_wdata(st_funct3, st_data);
                        mem_wstrb_d = lane_wstrb(st_funct3, st_addr[1:0]);
                    end else begin
                        state_d  = ERR;
                        st_err_d = 1'b1;
                    end
                end else begin
                    st_ready_d = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    // An ack on the final allowed cycle still counts as success.
                    state_d    = IDLE;
                    st_done_d  = 1'b1;
                    st_ready_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    st_err_d   = 1'b1;
                    st_ready_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q + TIMEOUT_W'(1);
                    mem_req_d   = 1'b1;
                    mem_wstrb_d = mem_wstrb_q;
                end
            end
            ERR: begin
                state_d    = IDLE;
                st_ready_d = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                st_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {TIMEOUT_W{1'b0}};
            st_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            st_ready_q  <= st_ready_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            st_done_q   <= st_done_d;
            st_err_q    <= st_err_d;
        end
    end

    assign st_ready  = st_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign st_done   = st_done_q;
    assign st_err    = st_err_q;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit.
// It runs directed cases followed by random stores.
// All expected values come from a lane-by-lane reference model.
// The timeout is shortened to 4 cycles so that timeouts are quick to reach.
module tb_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        st_done;
    logic        st_err;

    int errors = 0;
    int checks = 0;

    store_unit #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(8)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .st_done(st_done), .st_err(st_err)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value differs from the expected one.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size is 2^funct3 bytes.
    // The store occupies lanes [off, off+size), and lane i carries data byte (i mod size).
    function automatic int ref_size(input logic [2:0] f3);
        return (f3 <= 3'd2) ? (1 << f3) : 0;
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] a);
        int sz = ref_size(f3);
        return (sz != 0) && ((a % sz) == 0);
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s = 4'b0000;
        int sz  = ref_size(f3);
        int off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + sz) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w = 32'h0;
        int sz = ref_size(f3);
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    // Issues one store at the current negedge.
    // Memory acks in REQ cycle index ack_dly, counting from 0; an ack_dly of T or more means no ack arrives.
    // The task returns at the negedge where done or err is visible, which lets the next store start back-to-back.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f3, input int ack_dly);
        bit          legal = ref_legal(f3, a);
        logic [3:0]  es    = ref_wstrb(f3, a);
        logic [31:0] ew    = ref_wdata(f3, d);
        logic [31:0] ea    = a & 32'hFFFF_FFFC;
        bit          acked;
        int          k;
        chk("ready_before_accept", {31'b0, st_ready}, 32'd1);
        st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
        mem_ack  = 1'($urandom_range(0, 1));
        @(negedge clk);
        st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_funct3 = 3'($urandom);
        if (!legal) begin
            chk("err_pulse",      {31'b0, st_err},   32'd1);
            chk("err_no_req",     {31'b0, mem_req},  32'd0);
            chk("err_not_ready",  {31'b0, st_ready}, 32'd0);
            chk("err_no_done",    {31'b0, st_done},  32'd0);
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("err_clear",      {31'b0, st_err},   32'd0);
            chk("err_ready_back", {31'b0, st_ready}, 32'd1);
            chk("err_still_noreq",{31'b0, mem_req},  32'd0);
            mem_ack = 1'b0;
        end else begin
            k = 0;
            acked = 1'b0;
            while (1) begin
                chk("req_high",  {31'b0, mem_req},  32'd1);
                chk("req_addr",  mem_addr,           ea);
                chk("req_wdata", mem_wdata,          ew);
                chk("req_wstrb", {28'b0, mem_wstrb}, {28'b0, es});
                chk("req_busy",  {30'b0, st_ready, st_done}, 32'd0);
                mem_ack = (k == ack_dly);
                acked   = (k == ack_dly);
                if (acked || k == T - 1) break;
                k++;
                @(negedge clk);
            end
            @(negedge clk);
            mem_ack = 1'b0;
            chk("end_req_low", {31'b0, mem_req},  32'd0);
            chk("end_ready",   {31'b0, st_ready}, 32'd1);
            chk("end_done",    {31'b0, st_done},  {31'b0, acked});
            chk("end_err",     {31'b0, st_err},   {31'b0, !acked});
            chk("end_wstrb0",  {28'b0, mem_wstrb}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
        st_funct3 = 3'b0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {31'b0, st_ready}, 32'd1);
        chk("rst_req",   {31'b0, mem_req},  32'd0);
        chk("rst_addr",  mem_addr,           32'd0);
        chk("rst_wdata", mem_wdata,          32'd0);
        chk("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        chk("rst_pulse", {30'b0, st_done, st_err}, 32'd0);

        // Directed cases: an SB acked at once, then an SH acked on the third REQ cycle.
        do_store(32'h0000_1003, 32'h1234_5678, 3'b000, 0);
        do_store(32'h0000_2002, 32'hAABB_CCDD, 3'b001, 2);
        // A misaligned SW, then an illegal funct3.
        do_store(32'h0000_3001, 32'h1111_2222, 3'b010, 0);
        do_store(32'h0000_3000, 32'h1111_2222, 3'b011, 0);
        // A timeout with no ack, then an ack that lands on the last allowed cycle.
        do_store(32'h0000_0020, 32'hDEAD_BEEF, 3'b010, 99);
        do_store(32'h0000_0024, 32'hCAFE_F00D, 3'b010, T - 1);
        // Two back-to-back SWs.
        do_store(32'h0000_0010, 32'h0102_0304, 3'b010, 0);
        do_store(32'h0000_0014, 32'h0506_0708, 3'b010, 0);

        // Reset in the second REQ cycle: the request drops and neither done nor err is reported.
        chk("pre_rst_ready", {31'b0, st_ready}, 32'd1);
        st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h55AA_55AA; st_funct3 = 3'b010;
        @(negedge clk);
        st_valid = 1'b0;
        chk("rst_req_c1", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        chk("rst_req_c2", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_req",   {31'b0, mem_req},  32'd0);
        chk("midrst_ready", {31'b0, st_ready}, 32'd1);
        chk("midrst_pulse", {30'b0, st_done, st_err}, 32'd0);
        @(negedge clk);
        chk("midrst_quiet", {30'b0, st_done, st_err}, 32'd0);

        // Random stores with random funct3, address and ack delay.
        // The delay range includes no-ack, and some stores follow after idle gaps.
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            do_store(a, $urandom, f3, $urandom_range(0, T + 1));
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                mem_ack = 1'b0;
                chk("idle_noreq", {31'b0, mem_req}, 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
